// File: rtl/neuron_mac_serial.sv
// neuron_mac_serial: serial multiply-accumulate neuron.
// Consumes N_INPUTS sign-magnitude (x, w) beats, adds a bias, saturates the
// sum and emits one sign-magnitude Q4.11 pre-activation word per vector.
module neuron_mac_serial #(
  parameter int BITSIZE  = 16,
  parameter int FRAC     = 11,
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] x_in,
  input  logic [BITSIZE-1:0] w_in,
  input  logic [BITSIZE-1:0] bias,
  output logic [BITSIZE-1:0] data_out,
  output logic               out_valid
);

  localparam int MAG_W  = BITSIZE - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int PM_W   = PROD_W - FRAC;
  localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W:0] SAT_POS = (ACC_W+1)'((2 ** MAG_W) - 1);
  localparam logic signed [ACC_W:0] SAT_NEG = -SAT_POS;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    prod_q, prod_d;
  logic                prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]    bias_q, bias_d;
  logic [BITSIZE-1:0]  data_q, data_d;
  logic                ovalid_q, ovalid_d;

  logic [PROD_W-1:0]   prod_full;
  logic [PM_W-1:0]     prod_mag;
  logic [ACC_W-1:0]    prod_ext, prod_tc;
  logic [ACC_W-1:0]    bias_ext, bias_tc;
  logic signed [ACC_W:0] sum, sat, mag_full;
  logic [BITSIZE-1:0]  result;

  // Product and bias conversion from sign-magnitude to two's complement.
  always_comb begin
    prod_full = {{MAG_W{1'b0}}, x_in[MAG_W-1:0]} * {{MAG_W{1'b0}}, w_in[MAG_W-1:0]};
    prod_mag  = PM_W'(prod_full >> FRAC);
    prod_ext  = {{(ACC_W-PM_W){1'b0}}, prod_mag};
    // A zero magnitude negates to zero, so -0 never survives into the sum.
    prod_tc   = (x_in[BITSIZE-1] ^ w_in[BITSIZE-1]) ? -prod_ext : prod_ext;
    bias_ext  = {{(ACC_W-MAG_W){1'b0}}, bias[MAG_W-1:0]};
    bias_tc   = bias[BITSIZE-1] ? -bias_ext : bias_ext;
  end

  // Final sum, symmetric saturation and conversion back to sign-magnitude.
  always_comb begin
    sum = {acc_q[ACC_W-1], acc_q} + {bias_q[ACC_W-1], bias_q};
    if (sum > SAT_POS) begin
      sat = SAT_POS;
    end else if (sum < SAT_NEG) begin
      sat = SAT_NEG;
    end else begin
      sat = sum;
    end
    mag_full = sat[ACC_W] ? -sat : sat;
    result   = {sat[ACC_W], MAG_W'(mag_full)};
  end

  // Control FSM next state plus datapath register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    bias_d     = bias_q;
    data_d     = data_q;
    ovalid_d   = 1'b0;
    in_ready   = 1'b0;
    // Products land in the accumulator one edge after their accept.
    if (prod_vld_q) begin
      acc_d = acc_q + prod_q;
    end
    unique case (state_q)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          prod_d     = prod_tc;
          prod_vld_d = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            bias_d  = bias_tc;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        data_d   = result;
        ovalid_d = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ST_ACC;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      bias_q     <= '0;
      data_q     <= '0;
      ovalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      bias_q     <= bias_d;
      data_q     <= data_d;
      ovalid_q   <= ovalid_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = ovalid_q;

endmodule

// File: tb/tb_neuron_mac_serial.sv
// Scoreboard bench for neuron_mac_serial: driver pushes expected results,
// monitor pops and compares on every out_valid pulse.
module tb_neuron_mac_serial;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] w_in = '0;
  logic [15:0] bias = '0;
  logic [15:0] data_out;
  logic        out_valid;

  neuron_mac_serial #(
    .BITSIZE(16), .FRAC(11), .N_INPUTS(N), .ACC_W(24)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_in(w_in), .bias(bias),
    .data_out(data_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [15:0] vx[N];
  logic [15:0] vw[N];
  int prev_last = -100;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the number-format rules.
  function automatic logic [15:0] model(input logic [15:0] b);
    longint acc, p, s;
    logic [15:0] r;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      p = (longint'(vx[i][14:0]) * longint'(vw[i][14:0])) / 2048;
      if (vx[i][15] ^ vw[i][15]) acc = acc - p;
      else acc = acc + p;
    end
    s = acc + (b[15] ? -longint'(b[14:0]) : longint'(b[14:0]));
    if (s > 32767) s = 32767;
    if (s < -32767) s = -32767;
    if (s < 0) r = {1'b1, 15'(-s)};
    else r = {1'b0, 15'(s)};
    return r;
  endfunction

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got data 0x%0h expected no output", data_out);
      end else begin
        e = sb.pop_front();
        check("data_out", data_out, e.data);
        check("out_valid_cycle", cyc, e.cyc);
        check("in_ready_on_valid", in_ready, 1);
      end
    end
  end

  task automatic send_beat(input logic [15:0] x, input logic [15:0] w,
                           input logic [15:0] b, output int acyc);
    int n;
    n = 0;
    in_valid = 1'b1;
    x_in = x;
    w_in = w;
    bias = b;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready low %0d cycles expected 1", n);
    end
    @(posedge clk);
    #1;
    acyc = cyc;
  endtask

  task automatic send_vec(input logic [15:0] b, input int gapmax, input bit chk_start);
    int a, first;
    exp_t e;
    a = 0;
    first = 0;
    for (int i = 0; i < N; i++) begin
      if (gapmax > 0) begin
        int k;
        k = $urandom_range(0, gapmax);
        if (k > 0) begin
          in_valid = 1'b0;
          x_in = 16'($urandom);
          w_in = 16'($urandom);
          bias = 16'($urandom);
          repeat (k) @(posedge clk);
          #1;
        end
      end
      send_beat(vx[i], vw[i], (i == N-1) ? b : 16'($urandom), a);
      if (i == 0) first = a;
    end
    if (chk_start) check("next_vec_start_cycle", first, prev_last + 3);
    prev_last = a;
    e.data = model(b);
    e.cyc = a + 2;
    sb.push_back(e);
    bias = 16'($urandom);
  endtask

  task automatic set_all(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      vx[i] = x;
      vw[i] = w;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int a;
    logic [15:0] t;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_data_out", data_out, 16'h0000);
    reset = 1'b0;

    // Directed vectors, issued back to back with in_valid held high.
    set_all(16'h0800, 16'h0400); send_vec(16'h0000, 0, 1'b0);
    set_all(16'h0800, 16'h8400); send_vec(16'h0800, 0, 1'b1);
    set_all(16'h7FFF, 16'h7FFF); send_vec(16'h0000, 0, 1'b1);
    set_all(16'h7FFF, 16'hFFFF); send_vec(16'h0000, 0, 1'b1);
    set_all(16'h0001, 16'h0001); send_vec(16'h0000, 0, 1'b1);
    set_all(16'h8000, 16'h0800); send_vec(16'h8000, 0, 1'b1);
    set_all(16'h0800, 16'h0400); send_vec(16'h0000, 3, 1'b0);

    // Random vectors, mixing full-range and small magnitudes.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        t = 16'($urandom);
        if (r % 2 == 1) t[14:0] = t[14:0] >> $urandom_range(3, 9);
        vx[i] = t;
        t = 16'($urandom);
        if (r % 2 == 1) t[14:0] = t[14:0] >> $urandom_range(3, 9);
        vw[i] = t;
      end
      send_vec(16'($urandom), r % 3, 1'b0);
    end
    wait_drain();

    // Leave a non-zero result on data_out, then abort a partial vector.
    set_all(16'h0800, 16'h8400); send_vec(16'h0800, 0, 1'b0);
    wait_drain();
    set_all(16'h0800, 16'h0400);
    for (int i = 0; i < 3; i++) send_beat(vx[i], vw[i], 16'h1234, a);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_data_out", data_out, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    check("post_reset_data_out", data_out, 16'h0000);
    send_vec(16'h0000, 0, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
